// File: rtl/bali_pkg.sv
// bali_pkg: shared constants and payload types for the bali JVM-subset core.
// Holds ALU operation codes, JVM branch condition codes, named opcodes,
// the decoded-control struct and the registered execute-result struct.
package bali_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned CMPT_W  = 4;
  localparam int unsigned CNT_W   = 2;

  // ALU operation codes; C..F are unassigned and yield a zero result
  localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALUOP_W-1:0] ALU_MUL  = 4'h2;
  localparam logic [ALUOP_W-1:0] ALU_DIV  = 4'h3;
  localparam logic [ALUOP_W-1:0] ALU_REM  = 4'h4;
  localparam logic [ALUOP_W-1:0] ALU_NEG  = 4'h5;
  localparam logic [ALUOP_W-1:0] ALU_SHL  = 4'h6;
  localparam logic [ALUOP_W-1:0] ALU_SHR  = 4'h7;
  localparam logic [ALUOP_W-1:0] ALU_USHR = 4'h8;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'h9;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'hA;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'hB;

  // Branch conditions in JVM opcode order; 6 and 7 are never true
  localparam logic [2:0] CC_EQ = 3'd0;
  localparam logic [2:0] CC_NE = 3'd1;
  localparam logic [2:0] CC_LT = 3'd2;
  localparam logic [2:0] CC_GE = 3'd3;
  localparam logic [2:0] CC_GT = 3'd4;
  localparam logic [2:0] CC_LE = 3'd5;

  // Named opcodes
  localparam logic [OPC_W-1:0] OP_NOP       = 8'h00;
  localparam logic [OPC_W-1:0] OP_ICONST_M1 = 8'h02;
  localparam logic [OPC_W-1:0] OP_ICONST_0  = 8'h03;
  localparam logic [OPC_W-1:0] OP_ICONST_5  = 8'h08;
  localparam logic [OPC_W-1:0] OP_BIPUSH    = 8'h10;
  localparam logic [OPC_W-1:0] OP_SIPUSH    = 8'h11;
  localparam logic [OPC_W-1:0] OP_IADD      = 8'h60;
  localparam logic [OPC_W-1:0] OP_ISUB      = 8'h64;
  localparam logic [OPC_W-1:0] OP_IMUL      = 8'h68;
  localparam logic [OPC_W-1:0] OP_IDIV      = 8'h6C;
  localparam logic [OPC_W-1:0] OP_IREM      = 8'h70;
  localparam logic [OPC_W-1:0] OP_INEG      = 8'h74;
  localparam logic [OPC_W-1:0] OP_ISHL      = 8'h78;
  localparam logic [OPC_W-1:0] OP_ISHR      = 8'h7A;
  localparam logic [OPC_W-1:0] OP_IUSHR     = 8'h7C;
  localparam logic [OPC_W-1:0] OP_IAND      = 8'h7E;
  localparam logic [OPC_W-1:0] OP_IOR       = 8'h80;
  localparam logic [OPC_W-1:0] OP_IXOR      = 8'h82;
  localparam logic [OPC_W-1:0] OP_IFEQ      = 8'h99;
  localparam logic [OPC_W-1:0] OP_IFLE      = 8'h9E;
  localparam logic [OPC_W-1:0] OP_IF_ICMPEQ = 8'h9F;
  localparam logic [OPC_W-1:0] OP_IF_ICMPLE = 8'hA4;

  // Decoded control fields for one opcode
  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic               isaluop;
    logic               iscmp;
    logic               constpush;
    logic               stackwb;
    logic               illegal;
    logic [CMPT_W-1:0]  cmptype;
    logic [CNT_W-1:0]   argc;
    logic [CNT_W-1:0]   stackargs;
    logic [DATA_W-1:0]  constval;
  } dec_t;

  // Everything the unit registers on a capture
  typedef struct packed {
    dec_t              dec;
    logic [DATA_W-1:0] result_lo;
    logic [DATA_W-1:0] result_hi;
    logic              cmp_true;
    logic              div_by_zero;
  } exe_t;

  // Signed condition evaluation in JVM order
  function automatic logic eval_cond(input logic [2:0] cc,
                                     input logic signed [DATA_W-1:0] lhs,
                                     input logic signed [DATA_W-1:0] rhs);
    logic r;
    r = 1'b0;
    case (cc)
      CC_EQ:   r = (lhs == rhs);
      CC_NE:   r = (lhs != rhs);
      CC_LT:   r = (lhs <  rhs);
      CC_GE:   r = (lhs >= rhs);
      CC_GT:   r = (lhs >  rhs);
      CC_LE:   r = (lhs <= rhs);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_decode_unit_if.sv
// exec_decode_unit_if: capture request (valid, opcode, operands) from the
// control FSM and the registered decode/execute results back to it.
//   master: control FSM side, drives the request, receives results
//   slave : exec_decode_unit side
interface exec_decode_unit_if;
  import bali_pkg::*;

  logic                valid;
  logic [OPC_W-1:0]    opcode;
  logic [DATA_W-1:0]   operand_a;
  logic [DATA_W-1:0]   operand_b;

  logic [ALUOP_W-1:0]  aluop;
  logic                isaluop;
  logic                iscmp;
  logic                constpush;
  logic                stackwb;
  logic                illegal;
  logic [CMPT_W-1:0]   cmptype;
  logic [CNT_W-1:0]    argc;
  logic [CNT_W-1:0]    stackargs;
  logic [DATA_W-1:0]   constval;
  logic [DATA_W-1:0]   result_lo;
  logic [DATA_W-1:0]   result_hi;
  logic                cmp_true;
  logic                div_by_zero;
  logic                out_valid;

  modport master (
    output valid, opcode, operand_a, operand_b,
    input  aluop, isaluop, iscmp, constpush, stackwb, illegal, cmptype,
           argc, stackargs, constval, result_lo, result_hi, cmp_true,
           div_by_zero, out_valid
  );

  modport slave (
    input  valid, opcode, operand_a, operand_b,
    output aluop, isaluop, iscmp, constpush, stackwb, illegal, cmptype,
           argc, stackargs, constval, result_lo, result_hi, cmp_true,
           div_by_zero, out_valid
  );

endinterface

// File: rtl/int_alu.sv
// int_alu: combinational 32-bit integer ALU for the bali core.
//   operand_a   : value1 (deeper stack element), sole operand of NEG
//   operand_b   : value2 (top of stack), divisor / shift amount
//   op_select   : ALU operation code
//   result_lo   : low 32 bits of the result
//   result_hi   : high 32 bits of the MUL product, zero otherwise
//   div_by_zero : DIV/REM with a zero divisor
module int_alu
  import bali_pkg::*;
(
  input  logic [DATA_W-1:0]  operand_a,
  input  logic [DATA_W-1:0]  operand_b,
  input  logic [ALUOP_W-1:0] op_select,
  output logic [DATA_W-1:0]  result_lo,
  output logic [DATA_W-1:0]  result_hi,
  output logic               div_by_zero
);

  logic signed [2*DATA_W-1:0] w_a_ext;
  logic signed [2*DATA_W-1:0] w_b_ext;
  logic signed [2*DATA_W-1:0] w_product;
  logic [DATA_W-1:0]          w_a_mag;
  logic [DATA_W-1:0]          w_b_mag;
  logic [DATA_W-1:0]          w_divisor;
  logic [DATA_W-1:0]          w_quot_mag;
  logic [DATA_W-1:0]          w_rem_mag;
  logic [DATA_W-1:0]          w_quot;
  logic [DATA_W-1:0]          w_rem;
  logic                       w_b_zero;
  logic [4:0]                 w_shamt;

  // Full signed product
  always_comb begin
    w_a_ext   = {{DATA_W{operand_a[DATA_W-1]}}, operand_a};
    w_b_ext   = {{DATA_W{operand_b[DATA_W-1]}}, operand_b};
    w_product = w_a_ext * w_b_ext;
  end

  // Sign-magnitude divide: |MIN_INT| fits in 32 unsigned bits, so
  // MIN_INT / -1 naturally wraps back to MIN_INT with remainder 0.
  always_comb begin
    w_b_zero   = (operand_b == '0);
    w_a_mag    = operand_a[DATA_W-1] ? DATA_W'(-operand_a) : operand_a;
    w_b_mag    = operand_b[DATA_W-1] ? DATA_W'(-operand_b) : operand_b;
    w_divisor  = w_b_zero ? DATA_W'(1) : w_b_mag;
    w_quot_mag = w_a_mag / w_divisor;
    w_rem_mag  = w_a_mag % w_divisor;
    w_quot     = (operand_a[DATA_W-1] ^ operand_b[DATA_W-1]) ?
                 DATA_W'(-w_quot_mag) : w_quot_mag;
    w_rem      = operand_a[DATA_W-1] ? DATA_W'(-w_rem_mag) : w_rem_mag;
  end

  // Result select
  always_comb begin
    result_lo   = '0;
    result_hi   = '0;
    div_by_zero = 1'b0;
    w_shamt     = operand_b[4:0];
    case (op_select)
      ALU_ADD:  result_lo = operand_a + operand_b;
      ALU_SUB:  result_lo = operand_a - operand_b;
      ALU_MUL: begin
        result_lo = w_product[DATA_W-1:0];
        result_hi = w_product[2*DATA_W-1:DATA_W];
      end
      ALU_DIV: begin
        result_lo   = w_b_zero ? '0 : w_quot;
        div_by_zero = w_b_zero;
      end
      ALU_REM: begin
        result_lo   = w_b_zero ? '0 : w_rem;
        div_by_zero = w_b_zero;
      end
      ALU_NEG:  result_lo = DATA_W'(-operand_a);
      ALU_SHL:  result_lo = operand_a << w_shamt;
      ALU_SHR:  result_lo = DATA_W'($signed(operand_a) >>> w_shamt);
      ALU_USHR: result_lo = operand_a >> w_shamt;
      ALU_AND:  result_lo = operand_a & operand_b;
      ALU_OR:   result_lo = operand_a | operand_b;
      ALU_XOR:  result_lo = operand_a ^ operand_b;
      default:  result_lo = '0;
    endcase
  end

endmodule

// File: rtl/exec_decode_unit.sv
// exec_decode_unit: registered decode-and-execute stage of the bali core.
// On a valid capture it decodes the opcode, runs the ALU and the branch
// compare on the operands, and presents all results one cycle later with
// an out_valid pulse. Outputs hold between captures.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all outputs
//   bus : slave side of exec_decode_unit_if (request in, results out)
module exec_decode_unit
  import bali_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  exec_decode_unit_if.slave  bus
);

  dec_t              w_dec;
  logic [DATA_W-1:0] w_res_lo;
  logic [DATA_W-1:0] w_res_hi;
  logic              w_div_by_zero;
  logic [DATA_W-1:0] w_cmp_rhs;
  logic              w_cmp_true;

  exe_t              r_out;
  logic              r_out_valid;

  // Opcode decoder
  always_comb begin
    w_dec = '0;
    case (bus.opcode) inside
      OP_NOP: ;
      [OP_ICONST_M1:OP_ICONST_5]: begin
        w_dec.constpush = 1'b1;
        w_dec.stackwb   = 1'b1;
        w_dec.constval  = DATA_W'(bus.opcode) - DATA_W'(OP_ICONST_0);
      end
      OP_BIPUSH: begin
        w_dec.argc    = 2'd1;
        w_dec.stackwb = 1'b1;
      end
      OP_SIPUSH: begin
        w_dec.argc    = 2'd2;
        w_dec.stackwb = 1'b1;
      end
      OP_IADD, OP_ISUB, OP_IMUL, OP_IDIV, OP_IREM, OP_ISHL, OP_ISHR,
      OP_IUSHR, OP_IAND, OP_IOR, OP_IXOR: begin
        w_dec.isaluop   = 1'b1;
        w_dec.stackargs = 2'd2;
        w_dec.stackwb   = 1'b1;
        case (bus.opcode)
          OP_ISUB:  w_dec.aluop = ALU_SUB;
          OP_IMUL:  w_dec.aluop = ALU_MUL;
          OP_IDIV:  w_dec.aluop = ALU_DIV;
          OP_IREM:  w_dec.aluop = ALU_REM;
          OP_ISHL:  w_dec.aluop = ALU_SHL;
          OP_ISHR:  w_dec.aluop = ALU_SHR;
          OP_IUSHR: w_dec.aluop = ALU_USHR;
          OP_IAND:  w_dec.aluop = ALU_AND;
          OP_IOR:   w_dec.aluop = ALU_OR;
          OP_IXOR:  w_dec.aluop = ALU_XOR;
          default:  w_dec.aluop = ALU_ADD;
        endcase
      end
      OP_INEG: begin
        w_dec.isaluop   = 1'b1;
        w_dec.stackargs = 2'd1;
        w_dec.stackwb   = 1'b1;
        w_dec.aluop     = ALU_NEG;
      end
      [OP_IFEQ:OP_IFLE]: begin
        w_dec.iscmp     = 1'b1;
        w_dec.stackargs = 2'd1;
        w_dec.argc      = 2'd2;
        w_dec.cmptype   = {1'b0, 3'(bus.opcode - OP_IFEQ)};
      end
      [OP_IF_ICMPEQ:OP_IF_ICMPLE]: begin
        w_dec.iscmp     = 1'b1;
        w_dec.stackargs = 2'd2;
        w_dec.argc      = 2'd2;
        w_dec.cmptype   = {1'b1, 3'(bus.opcode - OP_IF_ICMPEQ)};
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  int_alu u_int_alu (
    .operand_a   (bus.operand_a),
    .operand_b   (bus.operand_b),
    .op_select   (w_dec.aluop),
    .result_lo   (w_res_lo),
    .result_hi   (w_res_hi),
    .div_by_zero (w_div_by_zero)
  );

  // Branch condition: against b for if_icmp<cond>, against zero for if<cond>
  always_comb begin
    w_cmp_rhs  = w_dec.cmptype[CMPT_W-1] ? bus.operand_b : '0;
    w_cmp_true = eval_cond(w_dec.cmptype[2:0], bus.operand_a, w_cmp_rhs);
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= bus.valid;
      if (bus.valid) begin
        r_out.dec         <= w_dec;
        r_out.result_lo   <= w_res_lo;
        r_out.result_hi   <= w_res_hi;
        r_out.cmp_true    <= w_cmp_true;
        r_out.div_by_zero <= w_div_by_zero;
      end
    end
  end

  assign bus.aluop       = r_out.dec.aluop;
  assign bus.isaluop     = r_out.dec.isaluop;
  assign bus.iscmp       = r_out.dec.iscmp;
  assign bus.constpush   = r_out.dec.constpush;
  assign bus.stackwb     = r_out.dec.stackwb;
  assign bus.illegal     = r_out.dec.illegal;
  assign bus.cmptype     = r_out.dec.cmptype;
  assign bus.argc        = r_out.dec.argc;
  assign bus.stackargs   = r_out.dec.stackargs;
  assign bus.constval    = r_out.dec.constval;
  assign bus.result_lo   = r_out.result_lo;
  assign bus.result_hi   = r_out.result_hi;
  assign bus.cmp_true    = r_out.cmp_true;
  assign bus.div_by_zero = r_out.div_by_zero;
  assign bus.out_valid   = r_out_valid;

endmodule

// File: tb/tb_exec_decode_unit.sv
// tb_exec_decode_unit: scoreboard bench for exec_decode_unit. The driver
// pushes a reference-model expectation for every capture; the monitor pops
// and compares on each out_valid pulse.
module tb_exec_decode_unit;

  typedef struct {
    logic [3:0]  aluop;
    logic        isaluop;
    logic        iscmp;
    logic        constpush;
    logic        stackwb;
    logic        illegal;
    logic [3:0]  cmptype;
    logic [1:0]  argc;
    logic [1:0]  stackargs;
    logic [31:0] constval;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        cmp_true;
    logic        div_by_zero;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   n_pushed;
  int   n_popped;
  exp_t sb_q[$];

  exec_decode_unit_if bus();

  exec_decode_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs,
                           input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model written from the opcode table and JVM integer semantics
  function automatic exp_t model(input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint q;
    longint rhs;
    logic [63:0] t;
    logic [4:0]  sh;
    e  = '{default: '0};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    if (op >= 8'h02 && op <= 8'h08) begin
      e.constpush = 1; e.stackwb = 1;
      e.constval  = 32'(int'(op) - 3);
    end else if (op == 8'h10) begin
      e.argc = 1; e.stackwb = 1;
    end else if (op == 8'h11) begin
      e.argc = 2; e.stackwb = 1;
    end else if (op == 8'h74) begin
      e.isaluop = 1; e.stackargs = 1; e.stackwb = 1; e.aluop = 4'h5;
    end else if (op >= 8'h99 && op <= 8'h9E) begin
      e.iscmp = 1; e.stackargs = 1; e.argc = 2;
      e.cmptype = 4'(int'(op) - 'h99);
    end else if (op >= 8'h9F && op <= 8'hA4) begin
      e.iscmp = 1; e.stackargs = 2; e.argc = 2;
      e.cmptype = 4'(8 + int'(op) - 'h9F);
    end else if (op != 8'h00) begin
      case (op)
        8'h60: e.aluop = 4'h0;  8'h64: e.aluop = 4'h1;
        8'h68: e.aluop = 4'h2;  8'h6C: e.aluop = 4'h3;
        8'h70: e.aluop = 4'h4;  8'h78: e.aluop = 4'h6;
        8'h7A: e.aluop = 4'h7;  8'h7C: e.aluop = 4'h8;
        8'h7E: e.aluop = 4'h9;  8'h80: e.aluop = 4'hA;
        8'h82: e.aluop = 4'hB;
        default: e.illegal = 1;
      endcase
      if (!e.illegal) begin
        e.isaluop = 1; e.stackargs = 2; e.stackwb = 1;
      end
    end
    case (e.aluop)
      4'h0: e.result_lo = 32'(sa + sb);
      4'h1: e.result_lo = 32'(sa - sb);
      4'h2: begin
        q = sa * sb;
        t = 64'(q);
        e.result_lo = t[31:0];
        e.result_hi = t[63:32];
      end
      4'h3: if (sb == 0) e.div_by_zero = 1; else e.result_lo = 32'(sa / sb);
      4'h4: if (sb == 0) e.div_by_zero = 1; else e.result_lo = 32'(sa % sb);
      4'h5: e.result_lo = 32'(-sa);
      4'h6: begin t = {32'b0, a} << sh; e.result_lo = t[31:0]; end
      4'h7: e.result_lo = 32'(sa >>> sh);
      4'h8: e.result_lo = a >> sh;
      4'h9: e.result_lo = a & b;
      4'hA: e.result_lo = a | b;
      4'hB: e.result_lo = a ^ b;
      default: e.result_lo = 0;
    endcase
    rhs = e.cmptype[3] ? sb : 0;
    case (e.cmptype[2:0])
      3'd0: e.cmp_true = (sa == rhs);
      3'd1: e.cmp_true = (sa != rhs);
      3'd2: e.cmp_true = (sa <  rhs);
      3'd3: e.cmp_true = (sa >= rhs);
      3'd4: e.cmp_true = (sa >  rhs);
      3'd5: e.cmp_true = (sa <= rhs);
      default: e.cmp_true = 0;
    endcase
    return e;
  endfunction

  task automatic check_all_zero(input string tag);
    check_val({tag, "_res_lo"}, 64'(bus.result_lo), 64'd0);
    check_val({tag, "_res_hi"}, 64'(bus.result_hi), 64'd0);
    check_val({tag, "_flags"},
              64'({bus.isaluop, bus.iscmp, bus.constpush, bus.stackwb,
                   bus.illegal, bus.cmp_true, bus.div_by_zero, bus.out_valid}),
              64'd0);
    check_val({tag, "_fields"},
              64'({bus.aluop, bus.cmptype, bus.argc, bus.stackargs}), 64'd0);
    check_val({tag, "_constval"}, 64'(bus.constval), 64'd0);
  endtask

  // Drive one capture at the falling edge and record its expectation
  task automatic drive(input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.valid     = 1'b1;
    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    sb_q.push_back(model(op, a, b));
    n_pushed++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.valid = 1'b0;
    end
  endtask

  // Monitor: checks the pulse against the sampled strobe, then the payload
  always @(posedge clk) begin
    logic v_smp;
    exp_t e;
    v_smp = bus.valid && !rst;
    #1;
    check_val("out_valid", 64'(bus.out_valid), 64'(v_smp));
    if (bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        n_popped++;
        check_val("aluop",       64'(bus.aluop),       64'(e.aluop));
        check_val("isaluop",     64'(bus.isaluop),     64'(e.isaluop));
        check_val("iscmp",       64'(bus.iscmp),       64'(e.iscmp));
        check_val("constpush",   64'(bus.constpush),   64'(e.constpush));
        check_val("stackwb",     64'(bus.stackwb),     64'(e.stackwb));
        check_val("illegal",     64'(bus.illegal),     64'(e.illegal));
        check_val("cmptype",     64'(bus.cmptype),     64'(e.cmptype));
        check_val("argc",        64'(bus.argc),        64'(e.argc));
        check_val("stackargs",   64'(bus.stackargs),   64'(e.stackargs));
        check_val("constval",    64'(bus.constval),    64'(e.constval));
        check_val("result_lo",   64'(bus.result_lo),   64'(e.result_lo));
        check_val("result_hi",   64'(bus.result_hi),   64'(e.result_hi));
        check_val("cmp_true",    64'(bus.cmp_true),    64'(e.cmp_true));
        check_val("div_by_zero", 64'(bus.div_by_zero), 64'(e.div_by_zero));
      end
    end
  end

  initial begin
    logic [7:0]  ops[16];
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    n_checks = 0; n_errors = 0; n_pushed = 0; n_popped = 0;
    ops = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h74, 8'h78, 8'h7A,
            8'h7C, 8'h7E, 8'h80, 8'h82, 8'h99, 8'h9C, 8'hA0, 8'hA3};
    rst = 1'b1;
    bus.valid = 1'b0; bus.opcode = '0; bus.operand_a = '0; bus.operand_b = '0;
    #12;
    check_all_zero("reset");
    idle(2);
    rst = 1'b0;
    idle(2);
    check_all_zero("post_reset");

    // Directed cases including the spec corner values
    drive(8'h60, 32'd5, 32'd7);
    idle(1);
    check_val("iadd_value", 64'(bus.result_lo), 64'd12);
    drive(8'h68, 32'h0001_0000, 32'h0001_0000);
    drive(8'h6C, 32'd7, 32'd0);
    drive(8'h6C, 32'h8000_0000, 32'hFFFF_FFFF);
    drive(8'h70, 32'hFFFF_FFF9, 32'd2);
    drive(8'h70, 32'h8000_0000, 32'hFFFF_FFFF);
    drive(8'h70, 32'd9, 32'd0);
    drive(8'hA1, 32'hFFFF_FFFD, 32'd2);
    drive(8'h9B, 32'd0, 32'd5);
    drive(8'h02, 32'd1, 32'd2);
    drive(8'h08, 32'd1, 32'd2);
    drive(8'hFF, 32'd3, 32'd4);
    drive(8'h00, 32'd3, 32'd4);
    drive(8'h10, 32'd3, 32'd4);
    drive(8'h11, 32'd3, 32'd4);
    drive(8'h74, 32'd5, 32'd0);
    drive(8'h7A, 32'h8000_0000, 32'd33);
    drive(8'h7C, 32'h8000_0000, 32'd33);
    drive(8'h78, 32'h0000_0003, 32'hFFFF_FFFF);
    drive(8'h9E, 32'h8000_0000, 32'd0);
    drive(8'hA4, 32'd2, 32'd2);
    drive(8'hA2, 32'hFFFF_FFFF, 32'd0);
    idle(3);
    check_val("hold_after_idle", 64'(bus.result_hi), 64'd0);

    // Mid-stream reset: a pending capture is discarded, outputs clear at once
    drive(8'h68, 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    idle(1);
    @(negedge clk);
    bus.valid = 1'b1; bus.opcode = 8'h60; bus.operand_a = 32'd1; bus.operand_b = 32'd1;
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    bus.valid = 1'b0;
    rst = 1'b0;
    idle(2);
    check_all_zero("after_reset_idle");

    // Randomised back-to-back traffic with gaps
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom_range(0, 255));
      else op = ops[$urandom_range(0, 15)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 6))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: a = 32'd0;
        3: b = a;
        default: ;
      endcase
      drive(op, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(4);
    check_val("sb_drained", 64'(sb_q.size()), 64'd0);
    check_val("pulse_count", 64'(n_popped), 64'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
